// File: rtl/decode_imm_ctrl.sv
// Decode-stage controller: classifies each fetched instruction, steers the
// shared immediate generator, and buffers decoded results in a 2-entry
// HEAD/SKID valid/ready buffer that execute drains. Flush empties the buffer.
module decode_imm_ctrl #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_instr,
    input  logic [N-1:0] in_pc,
    input  logic         flush,
    output logic [N-1:0] imm_instr,
    output logic [1:0]   imm_sel,
    input  logic [N-1:0] imm_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_instr,
    output logic [N-1:0] out_pc,
    output logic [N-1:0] out_imm,
    output logic         out_illegal
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] SEL_I = 2'd0;
    localparam logic [1:0] SEL_S = 2'd1;
    localparam logic [1:0] SEL_B = 2'd2;
    localparam logic [1:0] SEL_U = 2'd3;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_e;

    state_e state_q, state_d;

    // Decoded view of the incoming instruction
    logic [N-1:0] dec_imm;
    logic         dec_illegal;

    // Buffer entries
    logic [N-1:0] head_instr_q, head_pc_q, head_imm_q;
    logic         head_ill_q;
    logic [N-1:0] skid_instr_q, skid_pc_q, skid_imm_q;
    logic         skid_ill_q;

    // Handshake and load controls
    logic acc, fire;
    logic load_head_in, move_skid, load_skid;

    assign imm_instr = in_instr;

    // Opcode classification: immediate-generator select plus the value to store
    always_comb begin
        imm_sel     = SEL_I;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (in_instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                imm_sel = SEL_I;
                dec_imm = imm_in;
            end
            OPC_STORE: begin
                imm_sel = SEL_S;
                dec_imm = imm_in;
            end
            OPC_BRANCH: begin
                imm_sel = SEL_B;
                dec_imm = imm_in;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_sel = SEL_U;
                dec_imm = imm_in;
            end
            OPC_JAL: begin
                // The shared generator has no J format, so it is assembled here
                imm_sel = SEL_I;
                dec_imm = {{(N-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_OP: begin
                imm_sel = SEL_I;
                dec_imm = '0;
            end
            default: begin
                imm_sel     = SEL_I;
                dec_imm     = '0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush overrides every other transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (acc) state_d = S_ONE;
                S_ONE: begin
                    if (acc && !fire)      state_d = S_TWO;
                    else if (!acc && fire) state_d = S_EMPTY;
                end
                S_TWO:   if (fire) state_d = S_ONE;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // FSM outputs: handshake flags depend only on state (and flush blocking accept)
    always_comb begin
        in_ready  = (state_q != S_TWO) && !flush;
        out_valid = (state_q != S_EMPTY);
    end

    // Entry load controls derived from state and handshakes
    always_comb begin
        acc          = in_valid && in_ready;
        fire         = out_valid && out_ready;
        load_head_in = acc && ((state_q == S_EMPTY) || ((state_q == S_ONE) && fire));
        load_skid    = acc && (state_q == S_ONE) && !fire;
        move_skid    = !flush && (state_q == S_TWO) && fire;
    end

    // HEAD entry: loads from decode or from SKID; flush clears only the illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_imm_q   <= '0;
            head_ill_q   <= 1'b0;
        end else if (flush) begin
            head_ill_q   <= 1'b0;
        end else if (load_head_in) begin
            head_instr_q <= in_instr;
            head_pc_q    <= in_pc;
            head_imm_q   <= dec_imm;
            head_ill_q   <= dec_illegal;
        end else if (move_skid) begin
            head_instr_q <= skid_instr_q;
            head_pc_q    <= skid_pc_q;
            head_imm_q   <= skid_imm_q;
            head_ill_q   <= skid_ill_q;
        end
    end

    // SKID entry: captures an accept that arrives while HEAD is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_imm_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else if (flush) begin
            skid_ill_q   <= 1'b0;
        end else if (load_skid) begin
            skid_instr_q <= in_instr;
            skid_pc_q    <= in_pc;
            skid_imm_q   <= dec_imm;
            skid_ill_q   <= dec_illegal;
        end
    end

    assign out_instr   = head_instr_q;
    assign out_pc      = head_pc_q;
    assign out_imm     = head_imm_q;
    assign out_illegal = head_ill_q;

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Scoreboard bench for decode_imm_ctrl: directed scenarios followed by random
// traffic, checked against a queue-based reference model of the buffer.
module tb_decode_imm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush;
    logic [31:0] in_instr, in_pc, imm_instr, imm_in;
    logic [1:0]  imm_sel;
    logic        out_valid, out_ready, out_illegal;
    logic [31:0] out_instr, out_pc, out_imm;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ill;
        logic [1:0]  sel;
    } exp_t;

    exp_t sbq[$];
    exp_t pend;

    decode_imm_ctrl #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .imm_instr(imm_instr), .imm_sel(imm_sel), .imm_in(imm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // RISC-V immediate formats
    function automatic logic [31:0] fmt_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction
    function automatic logic [31:0] fmt_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction
    function automatic logic [31:0] fmt_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction
    function automatic logic [31:0] fmt_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction
    function automatic logic [31:0] fmt_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // External immediate generator driven by the DUT's select
    always_comb begin
        case (imm_sel)
            2'd0:    imm_in = fmt_i(imm_instr);
            2'd1:    imm_in = fmt_s(imm_instr);
            2'd2:    imm_in = fmt_b(imm_instr);
            default: imm_in = fmt_u(imm_instr);
        endcase
    end

    // Reference decode: what execute should receive for an instruction
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.instr = i; e.pc = p; e.imm = '0; e.ill = 1'b0; e.sel = 2'd0;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: e.imm = fmt_i(i);
            7'b0100011: begin e.sel = 2'd1; e.imm = fmt_s(i); end
            7'b1100011: begin e.sel = 2'd2; e.imm = fmt_b(i); end
            7'b0110111, 7'b0010111: begin e.sel = 2'd3; e.imm = fmt_u(i); end
            7'b1101111: e.imm = fmt_j(i);
            7'b0110011: e.imm = '0;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares handshake flags against model occupancy, pops on delivery,
    // and records accepted stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_ready, exp_valid;
            exp_t h;
            exp_ready = (sbq.size() < 2) && !flush;
            exp_valid = (sbq.size() > 0);
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
            chk("imm_sel", {30'b0, imm_sel}, {30'b0, pend.sel});
            chk("imm_instr", imm_instr, in_instr);
            if (flush) begin
                sbq.delete();
            end else begin
                if (exp_valid && out_ready) begin
                    h = sbq.pop_front();
                    chk("out_instr", out_instr, h.instr);
                    chk("out_pc", out_pc, h.pc);
                    chk("out_imm", out_imm, h.imm);
                    chk("out_illegal", {31'b0, out_illegal}, {31'b0, h.ill});
                end
                if (in_valid && exp_ready) sbq.push_back(pend);
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic fl, input logic ordy);
        @(posedge clk);
        #2;
        in_valid  = v;
        in_instr  = i;
        in_pc     = p;
        flush     = fl;
        out_ready = ordy;
        pend      = model(i, p);
    endtask

    logic [6:0] opcs [11] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
                              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
                              7'b1111111};

    initial begin
        logic [31:0] r, ri;
        int unsigned k;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        pend = model('0, '0);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // addi x1,x0,-1
        step(1, 32'hFFF00093, 32'h100, 0, 1);
        step(0, 32'h0, 32'h0, 0, 1);
        // JAL and LUI back to back
        step(1, 32'h0080006F, 32'h104, 0, 1);
        step(1, 32'h123450B7, 32'h108, 0, 1);
        step(0, 32'h0, 32'h0, 0, 1);
        // Stall: A, B fill buffer; C held off until space frees
        step(1, 32'h00A00113, 32'h200, 0, 0);
        step(1, 32'h00B00193, 32'h204, 0, 0);
        step(1, 32'h00C00213, 32'h208, 0, 0);
        step(1, 32'h00C00213, 32'h208, 0, 0);
        step(1, 32'h00C00213, 32'h208, 0, 1);
        step(1, 32'h00C00213, 32'h208, 0, 1);
        repeat (3) step(0, 32'h0, 32'h0, 0, 1);
        // Flush while full
        step(1, 32'h00802023, 32'h300, 0, 0);
        step(1, 32'hFE000EE3, 32'h304, 0, 0);
        step(0, 32'h0, 32'h0, 1, 1);
        repeat (3) step(0, 32'h0, 32'h0, 0, 1);
        // Illegal opcode followed by a legal one
        step(1, 32'hABCDE07F, 32'h400, 0, 1);
        step(1, 32'h00100093, 32'h404, 0, 1);
        step(0, 32'h0, 32'h0, 0, 1);
        // Async reset with HEAD and SKID occupied
        step(1, 32'h00500293, 32'h500, 0, 0);
        step(1, 32'h00600313, 32'h504, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("amid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("amid_out_instr", out_instr, 32'd0);
        chk("amid_out_pc", out_pc, 32'd0);
        chk("amid_out_imm", out_imm, 32'd0);
        chk("amid_out_illegal", {31'b0, out_illegal}, 32'd0);
        sbq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom();
            k  = $urandom_range(0, 12);
            ri = r;
            if (k < 11) ri[6:0] = opcs[k];
            step(($urandom_range(0, 9) < 7), ri, $urandom(),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 6));
        end

        // Drain with bounded wait
        for (int n = 0; n < 20; n++) begin
            if (sbq.size() == 0) break;
            step(0, 32'h0, 32'h0, 0, 1);
        end
        step(0, 32'h0, 32'h0, 0, 1);
        chk("drain_empty", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
